// File: rtl/core_ahbl_arbiter_pkg.sv
// Shared types, AHB-Lite encodings and byte-enable decode helpers for the
// core-to-AHB-Lite arbiter.
package core_ahbl_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'b00,
        OWN_INSTR = 2'b01,
        OWN_DATA  = 2'b10
    } ahbl_owner_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_B = 3'b000;
    localparam logic [2:0] HSIZE_H = 3'b001;
    localparam logic [2:0] HSIZE_W = 3'b010;

    localparam logic [3:0] HPROT_DATA  = 4'b0011;
    localparam logic [3:0] HPROT_INSTR = 4'b0010;

    // Only naturally aligned bytes and halfwords shrink the transfer; every
    // other enable pattern goes out as a full word.
    function automatic logic [2:0] be2hsize(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return HSIZE_B;
            4'b0011, 4'b1100:                   return HSIZE_H;
            default:                            return HSIZE_W;
        endcase
    endfunction

    function automatic logic [1:0] be2offset(input logic [3:0] be);
        case (be)
            4'b0010:          return 2'd1;
            4'b0100, 4'b1100: return 2'd2;
            4'b1000:          return 2'd3;
            default:          return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/core_ahbl_arb_sel.sv
// Winner select between fetch and load/store with a starvation guard that
// forces a fetch grant after STARVE_LIMIT back-to-back data grants.
module core_ahbl_arb_sel #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_cpu,
    input  logic rstn_cpu,
    input  logic addr_en,
    input  logic instr_req,
    input  logic data_req,
    output logic instr_gnt,
    output logic data_gnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_comb begin
        data_gnt  = addr_en && data_req && (!instr_req || (starve_cnt < LIMIT));
        instr_gnt = addr_en && instr_req && !data_gnt;
    end

    // Frozen whenever no address phase can be issued (wait state, error slot).
    always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
        if (!rstn_cpu) begin
            starve_cnt <= '0;
        end else if (addr_en) begin
            if (!instr_req || instr_gnt) begin
                starve_cnt <= '0;
            end else if (data_gnt && (starve_cnt < LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/core_ahbl_arbiter.sv
// Shares one AHB-Lite master port between the core fetch and load/store
// req/gnt/rvalid interfaces with a pipelined address/data phase.
module core_ahbl_arbiter
    import core_ahbl_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,

    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,

    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,

    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic [1:0]            htrans_o,
    output logic                  hwrite_o,
    output logic [2:0]            hsize_o,
    output logic [2:0]            hburst_o,
    output logic [3:0]            hprot_o,
    output logic                  hmastlock_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic                  hresp_i
);

    localparam logic [0:0] ERR_IDLE = 1'b0;
    localparam logic [0:0] ERR_WAIT = 1'b1;

    logic [0:0]            err_state;
    logic                  err1_q;
    logic                  addr_en;
    ahbl_owner_e           dp_owner;
    logic                  dp_we;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign err1_q = (err_state == ERR_WAIT);

    // Gating with the reset pin keeps grants low while reset is held.
    assign addr_en = sys_rstn_i && hready_i && !err1_q;

    core_ahbl_arb_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_sel (
        .clk_cpu   (sys_clk_i),
        .rstn_cpu  (sys_rstn_i),
        .addr_en   (addr_en),
        .instr_req (instr_req_i),
        .data_req  (data_req_i),
        .instr_gnt (instr_gnt_o),
        .data_gnt  (data_gnt_o)
    );

    // Address phase: driven straight from the winner, idle and zero otherwise.
    always_comb begin
        haddr_o  = '0;
        htrans_o = HTRANS_IDLE;
        hwrite_o = 1'b0;
        hsize_o  = HSIZE_B;
        hprot_o  = 4'b0000;
        if (data_gnt_o) begin
            haddr_o  = {data_addr_i[ADDR_WIDTH-1:2], be2offset(data_be_i)};
            htrans_o = HTRANS_NONSEQ;
            hwrite_o = data_we_i;
            hsize_o  = be2hsize(data_be_i);
            hprot_o  = HPROT_DATA;
        end else if (instr_gnt_o) begin
            haddr_o  = {instr_addr_i[ADDR_WIDTH-1:2], 2'b00};
            htrans_o = HTRANS_NONSEQ;
            hsize_o  = HSIZE_W;
            hprot_o  = HPROT_INSTR;
        end
    end

    assign hburst_o    = 3'b000;
    assign hmastlock_o = 1'b0;

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            dp_owner <= OWN_NONE;
            dp_we    <= 1'b0;
            wdata_q  <= '0;
        end else if (hready_i) begin
            if (data_gnt_o) begin
                dp_owner <= OWN_DATA;
                dp_we    <= data_we_i;
                wdata_q  <= data_wdata_i;
            end else if (instr_gnt_o) begin
                dp_owner <= OWN_INSTR;
                dp_we    <= 1'b0;
                wdata_q  <= data_wdata_i;
            end else begin
                dp_owner <= OWN_NONE;
                dp_we    <= 1'b0;
            end
        end
    end

    // First ERROR cycle (hready low) opens a one-slot window with no new grant.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            err_state <= ERR_IDLE;
        end else begin
            case (err_state)
                ERR_IDLE: if ((dp_owner != OWN_NONE) && hresp_i && !hready_i) err_state <= ERR_WAIT;
                ERR_WAIT: if (hready_i) err_state <= ERR_IDLE;
                default:  err_state <= ERR_IDLE;
            endcase
        end
    end

    assign hwdata_o = ((dp_owner == OWN_DATA) && dp_we) ? wdata_q : '0;

    assign instr_rvalid_o = hready_i && (dp_owner == OWN_INSTR);
    assign instr_rdata_o  = instr_rvalid_o ? hrdata_i : '0;
    assign instr_err_o    = instr_rvalid_o && hresp_i;

    assign data_rvalid_o  = hready_i && (dp_owner == OWN_DATA);
    assign data_rdata_o   = (data_rvalid_o && !dp_we) ? hrdata_i : '0;
    assign data_err_o     = data_rvalid_o && hresp_i;

endmodule

// File: tb/tb_core_ahbl_arbiter.sv
// Directed bench for core_ahbl_arbiter: address-phase checks inline, data-phase
// responses checked by a monitor against a queue of expected completions.
module tb_core_ahbl_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = 4'hF;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] data_rdata;
    logic [31:0] haddr, hwdata;
    logic [31:0] hrdata = '0;
    logic [1:0]  htrans;
    logic        hwrite, hmastlock;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    core_ahbl_arbiter dut (
        .sys_clk_i      (clk),
        .sys_rstn_i     (rstn),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .haddr_o        (haddr),
        .htrans_o       (htrans),
        .hwrite_o       (hwrite),
        .hsize_o        (hsize),
        .hburst_o       (hburst),
        .hprot_o        (hprot),
        .hmastlock_o    (hmastlock),
        .hwdata_o       (hwdata),
        .hrdata_i       (hrdata),
        .hready_i       (hready),
        .hresp_i        (hresp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit is_data, input logic [31:0] rdata, input bit err);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        e.err     = err;
        exp_q.push_back(e);
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (instr_rvalid || data_rvalid) begin
            checks++;
            if (instr_rvalid && data_rvalid) begin
                failures++;
                $display("FAIL rsp_both_rvalid actual=11 required=one-hot");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected actual instr_rvalid=%0b data_rvalid=%0b required=none",
                         instr_rvalid, data_rvalid);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_rvalid !== mon_e.is_data ||
                    (data_rvalid ? data_rdata : instr_rdata) !== mon_e.rdata ||
                    (data_rvalid ? data_err : instr_err) !== mon_e.err ||
                    (data_rvalid ? instr_rdata : data_rdata) !== 32'h0) begin
                    failures++;
                    $display("FAIL rsp actual is_data=%0b rdata=0x%08h err=%0b required is_data=%0b rdata=0x%08h err=%0b",
                             data_rvalid, data_rvalid ? data_rdata : instr_rdata,
                             data_rvalid ? data_err : instr_err,
                             mon_e.is_data, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    logic [3:0] be_tab   [7] = '{4'b0001, 4'b0010, 4'b1000, 4'b0011, 4'b1100, 4'b0110, 4'b1111};
    logic [2:0] size_tab [7] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2};
    logic [1:0] off_tab  [7] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0};

    initial begin
        logic [44:0] snap;

        // Reset held with both requests raised: nothing may leak out.
        instr_req = 1'b1;
        data_req  = 1'b1;
        @(negedge clk);
        chk("rst_gnt", {instr_gnt, data_gnt}, 2'b00);
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
        chk("rst_hwdata", hwdata, 32'h0);
        drive_edge();
        instr_req = 1'b0;
        data_req  = 1'b0;
        rstn      = 1'b1;
        @(negedge clk);
        chk("const_burst_lock", {hburst, hmastlock}, 4'b0000);

        // Single fetch.
        drive_edge();
        instr_req  = 1'b1;
        instr_addr = 32'h100;
        @(negedge clk);
        chk("t1_gnt", {instr_gnt, data_gnt}, 2'b10);
        chk("t1_addr_phase", {htrans, haddr, hsize, hwrite, hprot}, {2'b10, 32'h100, 3'b010, 1'b0, 4'b0010});
        push_exp(1'b0, 32'h1111_1111, 1'b0);
        drive_edge();
        instr_req = 1'b0;
        hrdata    = 32'h1111_1111;
        @(negedge clk);
        chk("t1_idle_after", {instr_gnt, htrans}, 3'b000);
        drive_edge();
        hrdata = '0;

        // Both requests held: starvation guard every fifth grant.
        instr_addr = 32'h200;
        data_addr  = 32'h3000;
        data_we    = 1'b0;
        data_be    = 4'hF;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) drive_edge();
            instr_req = 1'b1;
            data_req  = 1'b1;
            hrdata    = 32'hCAFE_0000 + i;
            @(negedge clk);
            chk($sformatf("t2_gnt%0d", i), {instr_gnt, data_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
            push_exp((i % 5 != 4), 32'hCAFE_0000 + i + 1, 1'b0);
        end
        drive_edge();
        instr_req = 1'b0;
        data_req  = 1'b0;
        hrdata    = 32'hCAFE_000A;
        @(negedge clk);

        // Byte store, then data must follow one cycle later from the register.
        drive_edge();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'b0100;
        data_addr  = 32'h2000;
        data_wdata = 32'hAABB_CCDD;
        hrdata     = '0;
        @(negedge clk);
        chk("t3_gnt", {instr_gnt, data_gnt}, 2'b01);
        chk("t3_addr_phase", {htrans, haddr, hsize, hwrite, hprot}, {2'b10, 32'h2002, 3'b000, 1'b1, 4'b0011});
        push_exp(1'b1, 32'h0, 1'b0);
        drive_edge();
        data_req   = 1'b0;
        data_wdata = '0;
        hrdata     = 32'h5555_5555;
        @(negedge clk);
        chk("t3_hwdata", hwdata, 32'hAABB_CCDD);

        // Byte-enable to size/offset table, issued as back-to-back loads.
        data_we   = 1'b0;
        data_addr = 32'h4000;
        for (int i = 0; i < 7; i++) begin
            drive_edge();
            data_req = 1'b1;
            data_be  = be_tab[i];
            hrdata   = 32'hB000_0000 + i;
            @(negedge clk);
            chk($sformatf("be_%b", be_tab[i]), {data_gnt, hsize, haddr},
                {1'b1, size_tab[i], 30'h1000, off_tab[i]});
            push_exp(1'b1, 32'hB000_0001 + i, 1'b0);
        end
        drive_edge();
        data_req = 1'b0;
        data_be  = 4'hF;
        hrdata   = 32'hB000_0007;
        @(negedge clk);
        chk("be_hwdata_load", hwdata, 32'h0);

        // Load with two wait states; a fetch waits behind it.
        drive_edge();
        data_req  = 1'b1;
        data_addr = 32'h5000;
        hrdata    = '0;
        @(negedge clk);
        chk("t4_gnt", data_gnt, 1'b1);
        push_exp(1'b1, 32'h7777_8888, 1'b0);
        drive_edge();
        data_req   = 1'b0;
        instr_req  = 1'b1;
        instr_addr = 32'h500;
        hready     = 1'b0;
        hrdata     = 32'hDEAD_DEAD;
        @(negedge clk);
        chk("t4_wait1_gnt", {instr_gnt, data_gnt}, 2'b00);
        chk("t4_wait1_idle", {htrans, haddr}, 34'h0);
        snap = {haddr, htrans, hwrite, hsize, hprot, instr_gnt, data_gnt, data_rvalid};
        drive_edge();
        @(negedge clk);
        chk("t4_wait2_stable", {haddr, htrans, hwrite, hsize, hprot, instr_gnt, data_gnt, data_rvalid}, snap);
        drive_edge();
        hready = 1'b1;
        hrdata = 32'h7777_8888;
        @(negedge clk);
        chk("t4_resume", {data_rvalid, instr_gnt, haddr}, {1'b1, 1'b1, 32'h500});
        push_exp(1'b0, 32'h9999_0000, 1'b0);
        drive_edge();
        instr_req = 1'b0;
        hrdata    = 32'h9999_0000;
        @(negedge clk);

        // Fetch hit by a two-cycle ERROR response.
        drive_edge();
        instr_req  = 1'b1;
        instr_addr = 32'h300;
        hrdata     = '0;
        @(negedge clk);
        chk("t5_gnt", instr_gnt, 1'b1);
        push_exp(1'b0, 32'h0, 1'b1);
        drive_edge();
        instr_addr = 32'h304;
        hready     = 1'b0;
        hresp      = 1'b1;
        @(negedge clk);
        chk("t5_err1_gnt", {instr_gnt, data_gnt}, 2'b00);
        drive_edge();
        hready = 1'b1;
        @(negedge clk);
        chk("t5_err2_idle", {htrans, instr_gnt, data_gnt}, 4'b0000);
        chk("t5_err2_rvalid", {instr_rvalid, instr_err}, 2'b11);
        drive_edge();
        hresp = 1'b0;
        @(negedge clk);
        chk("t5_regrant", {instr_gnt, htrans, haddr}, {1'b1, 2'b10, 32'h304});
        push_exp(1'b0, 32'h1234_5678, 1'b0);
        drive_edge();
        instr_req = 1'b0;
        hrdata    = 32'h1234_5678;
        @(negedge clk);

        // Reset during an outstanding load.
        drive_edge();
        data_req  = 1'b1;
        data_addr = 32'h6000;
        hrdata    = '0;
        @(negedge clk);
        chk("t6_gnt", data_gnt, 1'b1);
        drive_edge();
        hrdata = 32'hBAD0_BAD0;
        rstn   = 1'b0;
        #1;
        chk("t6_rst_outputs", {data_rvalid, data_gnt, htrans, haddr, data_rdata},
            {1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
        drive_edge();
        data_req = 1'b0;
        rstn     = 1'b1;
        @(negedge clk);
        chk("t6_no_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
        drive_edge();
        instr_req  = 1'b1;
        instr_addr = 32'h400;
        hrdata     = '0;
        @(negedge clk);
        chk("t6_first_gnt", {instr_gnt, htrans, haddr}, {1'b1, 2'b10, 32'h400});
        push_exp(1'b0, 32'h4040_4040, 1'b0);
        drive_edge();
        instr_req = 1'b0;
        hrdata    = 32'h4040_4040;
        @(negedge clk);
        drive_edge();
        hrdata = '0;
        @(negedge clk);
        @(negedge clk);

        chk("outstanding_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
